// File: rtl/rca64_accumulator.sv
// rca64_accumulator: sums a stream of 64-bit operands through one ripple-carry
// adder. The running total, the count of adds that carried out, and a sticky
// overflow flag are kept in registers. The total is returned on a valid/ready
// output port.
module rca64_accumulator #(
    parameter int WIDTH = 64,   // tied to the RCA64 datapath width
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             carry_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   carry_cnt_q, carry_cnt_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               first_q, first_d;
    logic               cin_q, cin_d;

    // RCA64 datapath: a = running total, b = incoming operand. The latched
    // carry is injected only into the first add of a run.
    logic [WIDTH-1:0]   rca_a, rca_b, rca_sum;
    logic               rca_cin, rca_c, rca_cout;

    assign rca_a   = result_q;
    assign rca_b   = in_data;
    assign rca_cin = first_q & cin_q;

    // Ripple-carry chain: each bit is a full adder that feeds its carry to the next bit.
    always_comb begin
        rca_sum = '0;
        rca_c   = rca_cin;
        for (int i = 0; i < WIDTH; i++) begin
            rca_sum[i] = rca_a[i] ^ rca_b[i] ^ rca_c;
            rca_c      = (rca_a[i] & rca_b[i]) | (rca_c & (rca_a[i] ^ rca_b[i]));
        end
        rca_cout = rca_c;
    end

    // Compute the next state and the next value of every register. Every
    // register holds its value unless a case below updates it.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_cnt_d = carry_cnt_q;
        overflow_d  = overflow_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        cin_d       = cin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cin_d       = carry_in;
                    carry_cnt_d = '0;
                    overflow_d  = 1'b0;
                    if (num_ops != '0) begin
                        result_d    = '0;
                        remaining_d = num_ops;
                        first_d     = 1'b1;
                        state_d     = ACCUM;
                    end else begin
                        // An empty sum still reports the initial carry.
                        result_d = {{(WIDTH-1){1'b0}}, carry_in};
                        state_d  = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    result_d    = rca_sum;
                    first_d     = 1'b0;
                    remaining_d = remaining_q - 1'b1;
                    if (rca_cout) begin
                        overflow_d = 1'b1;
                        if (carry_cnt_q != '1)
                            carry_cnt_d = carry_cnt_q + 1'b1;
                    end
                    if (remaining_q == CNT_W'(1))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. The synchronous reset takes priority over all other inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            carry_cnt_q <= '0;
            overflow_q  <= 1'b0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            cin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            carry_cnt_q <= carry_cnt_d;
            overflow_q  <= overflow_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            cin_q       <= cin_d;
        end
    end

    // The handshake outputs depend only on the state, so in_valid has no combinational path to in_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM) || (state_q == DONE);
    assign result    = result_q;
    assign carry_cnt = carry_cnt_q;
    assign overflow  = overflow_q;

endmodule
